sdram_minmax_scanner: RTL and testbench

SDRAM_MINMAX_SCANNER -- requirements
Module: sdram_minmax_scanner

---
 rtl/sdram_minmax_scanner.sv | 178 +++++++++++++++++
 tb/tb_sdram_minmax_scanner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_minmax_scanner.sv
// rtl/sdram_minmax_scanner.sv - Avalon-MM memory scanner that finds unsigned min/max over a word range.
// Optionally writes the min and max back to memory once the scan completes.
module sdram_minmax_scanner #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 32,
    parameter int MAX_OUT = 4,
    parameter int LEN_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [LEN_W-1:0]      length,
    input  logic [ADDR_W-1:0]     result_addr,
    output logic [ADDR_W-1:0]     address,
    output logic                  read,
    output logic                  write,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic [DATA_W-1:0]     writedata,
    input  logic                  waitrequest,
    input  logic                  readdatavalid,
    input  logic [DATA_W-1:0]     readdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     min_val,
    output logic [DATA_W-1:0]     max_val,
    output logic [LEN_W-1:0]      word_count
);

    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(DATA_W / 8);
    localparam logic [LEN_W-1:0]  OUT_LIM = LEN_W'(MAX_OUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WR_MIN,
        S_WR_MAX,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   res_q, res_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]    issued_q, issued_d;
    logic [LEN_W-1:0]    received_q, received_d;
    logic [DATA_W-1:0]   min_q, min_d;
    logic [DATA_W-1:0]   max_q, max_d;

    logic [LEN_W-1:0]    outstanding;
    logic                rd_req;
    logic                rd_acc;
    logic                rd_ret;

    // Issue decision uses registered counts only, so it cannot change during a stall.
    assign outstanding = issued_q - received_q;
    assign rd_req      = (state_q == S_READ) && (issued_q < len_q) && (outstanding < OUT_LIM);
    assign rd_acc      = rd_req && !waitrequest;
    assign rd_ret      = (state_q == S_READ) && readdatavalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            len_q      <= '0;
            res_q      <= '0;
            rd_addr_q  <= '0;
            issued_q   <= '0;
            received_q <= '0;
            min_q      <= '1;
            max_q      <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            res_q      <= res_d;
            rd_addr_q  <= rd_addr_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            min_q      <= min_d;
            max_q      <= max_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        res_d      = res_q;
        rd_addr_d  = rd_addr_q;
        issued_d   = issued_q;
        received_d = received_q;
        min_d      = min_q;
        max_d      = max_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    len_d      = length;
                    res_d      = result_addr;
                    rd_addr_d  = base_addr;
                    issued_d   = '0;
                    received_d = '0;
                    min_d      = '1;
                    max_d      = '0;
                    state_d    = (length == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (rd_acc) begin
                    issued_d  = issued_q + LEN_W'(1);
                    rd_addr_d = rd_addr_q + STEP;
                end
                if (rd_ret) begin
                    received_d = received_q + LEN_W'(1);
                    if (readdata < min_q) begin
                        min_d = readdata;
                    end
                    if (readdata > max_q) begin
                        max_d = readdata;
                    end
                    if ((received_q + LEN_W'(1)) == len_q) begin
                        state_d = mode_q ? S_WR_MIN : S_DONE;
                    end
                end
            end
            S_WR_MIN: begin
                if (!waitrequest) begin
                    state_d = S_WR_MAX;
                end
            end
            S_WR_MAX: begin
                if (!waitrequest) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        address   = '0;
        writedata = '0;
        case (state_q)
            S_READ:   address = rd_addr_q;
            S_WR_MIN: begin
                address   = res_q;
                writedata = min_q;
            end
            S_WR_MAX: begin
                address   = res_q + STEP;
                writedata = max_q;
            end
            default: begin
                address   = '0;
                writedata = '0;
            end
        endcase
    end

    assign read       = rd_req;
    assign write      = (state_q == S_WR_MIN) || (state_q == S_WR_MAX);
    assign byteenable = '1;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign min_val    = min_q;
    assign max_val    = max_q;
    assign word_count = received_q;

endmodule

// File: tb/tb_sdram_minmax_scanner.sv
// tb/tb_sdram_minmax_scanner.sv - Self-checking bench with an Avalon slave model and min/max reference.
module tb_sdram_minmax_scanner;

    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [31:0] base_addr;
    logic [15:0] length;
    logic [31:0] result_addr;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [1:0]  byteenable;
    logic [15:0] writedata;
    logic        waitrequest;
    logic        readdatavalid;
    logic [15:0] readdata;
    logic        busy;
    logic        done;
    logic [15:0] min_val;
    logic [15:0] max_val;
    logic [15:0] word_count;

    sdram_minmax_scanner #(
        .DATA_W(16), .ADDR_W(32), .MAX_OUT(MAX_OUT), .LEN_W(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .length(length), .result_addr(result_addr),
        .address(address), .read(read), .write(write), .byteenable(byteenable),
        .writedata(writedata), .waitrequest(waitrequest),
        .readdatavalid(readdatavalid), .readdata(readdata),
        .busy(busy), .done(done), .min_val(min_val), .max_val(max_val),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    logic [15:0] mem [256];

    int          cyc;
    int          latency;
    int          stall_pct;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          outst, acc_reads, ret_words;
    int          err_addr, err_stall, err_rw, err_out;
    logic [31:0] next_addr;
    logic        prev_stall;
    logic [31:0] prev_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] a);
        return int'(a[8:1]);
    endfunction

    // One bus cycle: slave drives inputs, observes master, then the clock edge.
    task automatic step();
        waitrequest = ($urandom_range(99) < stall_pct);
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            readdatavalid = 1'b1;
            readdata      = mem[idx(pend_addr[0])];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            outst--;
            ret_words++;
        end else begin
            readdatavalid = 1'b0;
            readdata      = 16'($urandom);
        end
        #1;
        if (read && write) err_rw++;
        if (read) begin
            if (prev_stall && address !== prev_addr) err_stall++;
            if (!waitrequest) begin
                if (address !== next_addr) err_addr++;
                next_addr = next_addr + 32'd2;
                pend_addr.push_back(address);
                pend_due.push_back(cyc + latency);
                outst++;
                acc_reads++;
            end
            prev_stall = waitrequest;
            prev_addr  = address;
        end else begin
            if (prev_stall) err_stall++;
            prev_stall = 1'b0;
        end
        if (outst > MAX_OUT) err_out++;
        if (write && !waitrequest) begin
            wr_addr.push_back(address);
            wr_data.push_back(writedata);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_model(input logic [31:0] base);
        pend_addr.delete(); pend_due.delete();
        wr_addr.delete(); wr_data.delete();
        outst = 0; acc_reads = 0; ret_words = 0;
        err_addr = 0; err_stall = 0; err_rw = 0; err_out = 0;
        next_addr = base; prev_stall = 1'b0; prev_addr = '0;
    endtask

    task automatic launch(input logic m, input logic [31:0] base, input logic [15:0] len,
                          input logic [31:0] res);
        clear_model(base);
        start = 1'b1; mode = m; base_addr = base; length = len; result_addr = res;
        step();
        start = 1'b0;
        // Parameter inputs change while busy; the scan must not notice.
        mode = ~m; base_addr = 32'($urandom); length = 16'($urandom); result_addr = 32'($urandom);
    endtask

    task automatic run_scan(input string tag, input logic m, input logic [31:0] base,
                            input logic [15:0] len, input logic [31:0] res);
        logic [15:0] emin, emax;
        int          budget;
        emin = 16'hFFFF;
        emax = 16'h0000;
        for (int i = 0; i < int'(len); i++) begin
            logic [15:0] w;
            w = mem[idx(base + 32'(2 * i))];
            if (w < emin) emin = w;
            if (w > emax) emax = w;
        end
        launch(m, base, len, res);
        chk({tag, ".first_read"}, {63'd0, read}, 64'd1);
        chk({tag, ".first_addr"}, 64'(address), 64'(base));
        budget = 0;
        while (!done && budget < 3000) begin
            step();
            budget++;
        end
        chk({tag, ".finished"}, {63'd0, done}, 64'd1);
        chk({tag, ".busy"}, {63'd0, busy}, 64'd0);
        chk({tag, ".min"}, 64'(min_val), 64'(emin));
        chk({tag, ".max"}, 64'(max_val), 64'(emax));
        chk({tag, ".count"}, 64'(word_count), 64'(len));
        chk({tag, ".reads"}, 64'(acc_reads), 64'(len));
        chk({tag, ".returns"}, 64'(ret_words), 64'(len));
        chk({tag, ".addr_seq"}, 64'(err_addr), 64'd0);
        chk({tag, ".stall_hold"}, 64'(err_stall), 64'd0);
        chk({tag, ".rd_wr_overlap"}, 64'(err_rw), 64'd0);
        chk({tag, ".outstanding"}, 64'(err_out), 64'd0);
        chk({tag, ".writes"}, 64'(wr_addr.size()), m ? 64'd2 : 64'd0);
        if (m && wr_addr.size() == 2) begin
            chk({tag, ".wr_min_addr"}, 64'(wr_addr[0]), 64'(res));
            chk({tag, ".wr_min_data"}, 64'(wr_data[0]), 64'(emin));
            chk({tag, ".wr_max_addr"}, 64'(wr_addr[1]), 64'(res + 32'd2));
            chk({tag, ".wr_max_data"}, 64'(wr_data[1]), 64'(emax));
        end
        step();
        step();
        chk({tag, ".back_idle"}, {62'd0, done, busy}, 64'd0);
        chk({tag, ".held_min"}, 64'(min_val), 64'(emin));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; length = '0;
        result_addr = '0; waitrequest = 1'b0; readdatavalid = 1'b0; readdata = '0;
        cyc = 0; latency = 1; stall_pct = 0;
        clear_model(32'd0);
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.outputs", {read, write, busy, done}, 64'd0);
        chk("reset.address", 64'(address), 64'd0);
        chk("reset.min", 64'(min_val), 64'hFFFF);
        chk("reset.max", 64'(max_val), 64'd0);
        chk("reset.byteenable", 64'(byteenable), 64'h3);
        reset = 1'b0;
        step();

        mem[0] = 16'd5; mem[1] = 16'd3; mem[2] = 16'd9; mem[3] = 16'd4; mem[4] = 16'd7;
        mem[5] = 16'd2; mem[6] = 16'd8; mem[7] = 16'd6; mem[8] = 16'd5; mem[9] = 16'd1;
        latency = 1; stall_pct = 0;
        run_scan("basic", 1'b0, 32'h0, 16'd10, 32'h0);

        latency = 8; stall_pct = 0;
        run_scan("lat8", 1'b0, 32'h40, 16'd20, 32'h0);

        latency = 2; stall_pct = 40;
        run_scan("stall", 1'b0, 32'h80, 16'd30, 32'h0);

        latency = 3; stall_pct = 30;
        run_scan("wb", 1'b1, 32'h20, 16'd12, 32'h100);

        latency = 1; stall_pct = 0;
        run_scan("wrap", 1'b0, 32'hFFFF_FFFC, 16'd4, 32'h0);

        // Zero length: straight to DONE with no bus activity.
        launch(1'b0, 32'h10, 16'd0, 32'h0);
        chk("len0.done", {62'd0, done, busy}, 64'b10);
        chk("len0.bus", {62'd0, read, write}, 64'd0);
        chk("len0.min", 64'(min_val), 64'hFFFF);
        chk("len0.max", 64'(max_val), 64'd0);
        step();
        step();

        // Reset with three reads in flight; their late data must be ignored.
        latency = 8; stall_pct = 0;
        launch(1'b0, 32'h0, 16'd10, 32'h0);
        for (int k = 0; k < 20 && outst < 3; k++) step();
        chk("rst.outstanding", 64'(outst), 64'd3);
        reset = 1'b1;
        #1;
        chk("rst.outputs", {read, write, busy, done}, 64'd0);
        chk("rst.address", 64'(address), 64'd0);
        chk("rst.min", 64'(min_val), 64'hFFFF);
        chk("rst.max", 64'(max_val), 64'd0);
        chk("rst.count", 64'(word_count), 64'd0);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) step();
        chk("rst.late_count", 64'(ret_words), 64'd3);
        chk("rst.late_min", 64'(min_val), 64'hFFFF);
        chk("rst.late_max", 64'(max_val), 64'd0);
        chk("rst.late_wc", 64'(word_count), 64'd0);

        latency = 2; stall_pct = 20;
        run_scan("after_rst", 1'b1, 32'h0, 16'd10, 32'h200);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
